vram_arbiter: RTL

//  Shares one single-port framebuffer RAM between VGA scanout reads and a draw-side writer.

---
 rtl/vram_arbiter.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port framebuffer RAM between VGA scanout
// reads and a queued draw-side writer. Scanout owns the port on visible
// cycles. Queued writes retire during blanking.
//
// Optional feature macro: VRAM_CLEAR_EN enables the hardware clear engine
// (IDLE -> DRAIN -> FILL -> IDLE). When it is undefined, clr_start and
// clr_color are ignored and clr_busy is tied low.
//
// Ports:
//   vclk, srst      video clock, synchronous active-high reset
//   disp_addr       scanout address
//   disp_visible    scanout is in the visible area
//   disp_pixel      pixel returned to vga (0 when not visible)
//   wr_valid/ready  write handshake
//   wr_addr/data    write address and pixel
//   mem_addr        RAM address
//   mem_we          RAM write enable
//   mem_wdata       RAM write data
//   mem_rdata       RAM read data, combinational from mem_addr
//   fifo_level      number of queued writes, 0..FIFO_DEPTH
//   wr_oob          sticky flag: an out-of-range write was popped
//   clr_start       one-cycle clear request
//   clr_color       clear pixel, sampled on clr_start
//   clr_busy        clear sequence in progress
module vram_arbiter #(
    parameter int unsigned ADDR_W     = 20,
    parameter int unsigned DATA_W     = 3,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned FB_WORDS   = 307200
) (
    input  logic                          vclk,
    input  logic                          srst,
    input  logic [ADDR_W-1:0]             disp_addr,
    input  logic                          disp_visible,
    output logic [DATA_W-1:0]             disp_pixel,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic                          mem_we,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          wr_oob,
    input  logic                          clr_start,
    input  logic [DATA_W-1:0]             clr_color,
    output logic                          clr_busy
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    // One extra bit so FB_WORDS itself is representable for the range check.
    localparam logic [ADDR_W:0] FB_LIM = (ADDR_W+1)'(FB_WORDS);

    // Write FIFO storage and pointers
    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    logic              full_c;
    logic              empty_c;
    logic              push_c;
    logic              pop_c;
    logic [ADDR_W-1:0] head_addr_c;
    logic [DATA_W-1:0] head_data_c;
    logic              head_oob_c;

    // Clear engine view seen by the grant logic
    logic              clr_idle_c;
    logic              clr_fill_c;
    logic [ADDR_W-1:0] clr_addr_c;
    logic [DATA_W-1:0] clr_wdata_c;

    assign full_c      = (fifo_level == LVL_W'(FIFO_DEPTH));
    assign empty_c     = (fifo_level == LVL_W'(0));
    assign head_addr_c = fifo_addr[rd_ptr];
    assign head_data_c = fifo_data[rd_ptr];
    assign head_oob_c  = ({1'b0, head_addr_c} >= FB_LIM);

    // Accept decision uses only registered state, plus srst to hold it low in reset.
    assign wr_ready = !full_c && clr_idle_c && !srst;
    assign push_c   = wr_valid && wr_ready;

`ifdef VRAM_CLEAR_EN
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_FILL  = 2'd2;
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(FB_WORDS - 1);

    logic [1:0]        clr_state;
    logic [1:0]        clr_state_nxt;
    logic [ADDR_W-1:0] clr_cnt;
    logic [ADDR_W-1:0] clr_cnt_nxt;
    logic [DATA_W-1:0] clr_color_q;
    logic [DATA_W-1:0] clr_color_nxt;

    // Clear FSM state register
    always_ff @(posedge vclk) begin
        if (srst) begin
            clr_state   <= ST_IDLE;
            clr_cnt     <= '0;
            clr_color_q <= '0;
            clr_busy    <= 1'b0;
        end else begin
            clr_state   <= clr_state_nxt;
            clr_cnt     <= clr_cnt_nxt;
            clr_color_q <= clr_color_nxt;
            clr_busy    <= (clr_state_nxt != ST_IDLE);
        end
    end

    // Clear FSM next state; the fill counter only advances on blanking cycles.
    always_comb begin
        clr_state_nxt = clr_state;
        clr_cnt_nxt   = clr_cnt;
        clr_color_nxt = clr_color_q;
        case (clr_state)
            ST_IDLE: begin
                if (clr_start) begin
                    clr_state_nxt = ST_DRAIN;
                    clr_color_nxt = clr_color;
                    clr_cnt_nxt   = '0;
                end
            end
            ST_DRAIN: begin
                if (empty_c) begin
                    clr_state_nxt = ST_FILL;
                end
            end
            ST_FILL: begin
                if (!disp_visible) begin
                    if (clr_cnt == CLR_LAST) begin
                        clr_state_nxt = ST_IDLE;
                        clr_cnt_nxt   = '0;
                    end else begin
                        clr_cnt_nxt = clr_cnt + ADDR_W'(1);
                    end
                end
            end
            default: begin
                clr_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign clr_idle_c  = (clr_state == ST_IDLE);
    assign clr_fill_c  = (clr_state == ST_FILL);
    assign clr_addr_c  = clr_cnt;
    assign clr_wdata_c = clr_color_q;
`else
    logic unused_clr_c;

    assign unused_clr_c = ^{clr_start, clr_color};
    assign clr_busy     = 1'b0;
    assign clr_idle_c   = 1'b1;
    assign clr_fill_c   = 1'b0;
    assign clr_addr_c   = '0;
    assign clr_wdata_c  = '0;
`endif

    // Port grant: display > clear fill > FIFO pop > idle
    always_comb begin
        mem_addr   = disp_addr;
        mem_we     = 1'b0;
        mem_wdata  = '0;
        disp_pixel = '0;
        pop_c      = 1'b0;
        if (disp_visible) begin
            disp_pixel = mem_rdata;
        end else if (clr_fill_c) begin
            mem_addr  = clr_addr_c;
            mem_we    = 1'b1;
            mem_wdata = clr_wdata_c;
        end else if (!empty_c) begin
            // Out-of-range entries are popped and dropped without a RAM write.
            pop_c     = 1'b1;
            mem_addr  = head_addr_c;
            mem_wdata = head_data_c;
            mem_we    = !head_oob_c;
        end
    end

    // FIFO pointers, level and sticky out-of-range flag
    always_ff @(posedge vclk) begin
        if (srst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            wr_oob     <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_level <= fifo_level + LVL_W'(push_c) - LVL_W'(pop_c);
            if (pop_c && head_oob_c) begin
                wr_oob <= 1'b1;
            end
        end
    end

    // FIFO storage, no reset needed
    always_ff @(posedge vclk) begin
        if (push_c) begin
            fifo_addr[wr_ptr] <= wr_addr;
            fifo_data[wr_ptr] <= wr_data;
        end
    end

endmodule
